// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mstatus.MIE/MPIE and mie, builds mip,
// and offers the highest-priority enabled pending interrupt to the pipeline.
module irq_ctrl #(
   parameter int Xlen       = 64,
   parameter int SyncStages = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            msip_i,
   input  logic            mtip_i,
   input  logic            meip_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [Xlen-1:0] csr_wdata_i,
   output logic [Xlen-1:0] csr_rdata_o,
   output logic            irq_req_o,
   output logic [Xlen-1:0] irq_cause_o,
   input  logic            irq_ack_i,
   input  logic            mret_i
);

   localparam logic [0:0]  ST_IDLE      = 1'b0;
   localparam logic [0:0]  ST_REQ       = 1'b1;
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MIE     = 12'h304;
   localparam logic [11:0] ADDR_MIP     = 12'h344;
   localparam logic [11:0] IRQ_MASK     = 12'h888;

   logic [0:0]            state_q;
   logic [SyncStages-1:0] sync_q;
   logic                  meip_s;
   logic [11:0]           mip;
   logic [11:0]           mie_q;
   logic [11:0]           mie_d;
   logic [11:0]           pend;
   logic [11:0]           pend_nx;
   logic [11:0]           src_q;
   logic [11:0]           sel_hot;
   logic [3:0]            sel_code;
   logic                  mst_mie_q;
   logic                  mst_mpie_q;
   logic                  mst_mie_d;
   logic                  mst_mpie_d;
   logic                  take;
   logic                  withdraw;
   logic                  elig;
   logic [Xlen-1:0]       cause_q;
   logic                  unused_wdata;

   assign unused_wdata = ^csr_wdata_i[Xlen-1:12];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) sync_q <= '0;
      else       sync_q <= {sync_q[SyncStages-2:0], meip_i};
   end

   assign meip_s  = sync_q[SyncStages-1];
   assign mip     = {meip_s, 3'b000, mtip_i, 3'b000, msip_i, 3'b000};
   assign mie_d   = (csr_we_i && csr_addr_i == ADDR_MIE) ? (csr_wdata_i[11:0] & IRQ_MASK) : mie_q;
   assign pend    = mip & mie_q;
   assign pend_nx = mip & mie_d;
   assign elig    = mst_mie_q & (|pend);
   assign take    = (state_q == ST_REQ) && irq_ack_i;

   always_comb begin
      sel_code = 4'd7;
      sel_hot  = 12'h080;
      if (pend[11]) begin
         sel_code = 4'd11;
         sel_hot  = 12'h800;
      end else if (pend[3]) begin
         sel_code = 4'd3;
         sel_hot  = 12'h008;
      end
   end

   // ack outranks mret, which outranks a CSR write of mstatus.
   always_comb begin
      mst_mie_d  = mst_mie_q;
      mst_mpie_d = mst_mpie_q;
      if (take) begin
         mst_mpie_d = mst_mie_q;
         mst_mie_d  = 1'b0;
      end else if (mret_i) begin
         mst_mie_d  = mst_mpie_q;
         mst_mpie_d = 1'b1;
      end else if (csr_we_i && csr_addr_i == ADDR_MSTATUS) begin
         mst_mie_d  = csr_wdata_i[3];
         mst_mpie_d = csr_wdata_i[7];
      end
   end

   // Withdraw looks at next-cycle enables so a disabling write drops the request one cycle later.
   assign withdraw = (state_q == ST_REQ) && !irq_ack_i && (!mst_mie_d || ((src_q & pend_nx) == 12'h000));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cause_q    <= '0;
         src_q      <= '0;
         mie_q      <= '0;
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
      end else begin
         mie_q      <= mie_d;
         mst_mie_q  <= mst_mie_d;
         mst_mpie_q <= mst_mpie_d;
         case (state_q)
            ST_IDLE: begin
               if (elig) begin
                  state_q <= ST_REQ;
                  cause_q <= {1'b1, {(Xlen-5){1'b0}}, sel_code};
                  src_q   <= sel_hot;
               end
            end
            ST_REQ: begin
               if (take || withdraw) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign irq_req_o   = (state_q == ST_REQ);
   assign irq_cause_o = cause_q;

   always_comb begin
      csr_rdata_o = '0;
      case (csr_addr_i)
         ADDR_MSTATUS: begin
            csr_rdata_o[3] = mst_mie_q;
            csr_rdata_o[7] = mst_mpie_q;
         end
         ADDR_MIE: csr_rdata_o[11:0] = mie_q;
         ADDR_MIP: csr_rdata_o[11:0] = mip;
         default:  ;
      endcase
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector table for irq_ctrl plus an asynchronous-reset sequence in REQ.
module tb_irq_ctrl;

   localparam logic [63:0] C3  = 64'h8000_0000_0000_0003;
   localparam logic [63:0] C7  = 64'h8000_0000_0000_0007;
   localparam logic [63:0] CB  = 64'h8000_0000_0000_000B;
   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic        msip;
      logic        mtip;
      logic        meip;
      logic        ack;
      logic        mret;
      logic        exp_req;
      logic [63:0] exp_cause;
      logic [63:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        msip = 1'b0;
   logic        mtip = 1'b0;
   logic        meip = 1'b0;
   logic        csr_we = 1'b0;
   logic [11:0] csr_addr = 12'h000;
   logic [63:0] csr_wdata = '0;
   logic [63:0] csr_rdata;
   logic        irq_req;
   logic [63:0] irq_cause;
   logic        irq_ack = 1'b0;
   logic        mret = 1'b0;

   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vq[$];

   irq_ctrl #(.Xlen(64), .SyncStages(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .msip_i      (msip),
      .mtip_i      (mtip),
      .meip_i      (meip),
      .csr_we_i    (csr_we),
      .csr_addr_i  (csr_addr),
      .csr_wdata_i (csr_wdata),
      .csr_rdata_o (csr_rdata),
      .irq_req_o   (irq_req),
      .irq_cause_o (irq_cause),
      .irq_ack_i   (irq_ack),
      .mret_i      (mret)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
   endtask

   task automatic add(input logic we, input logic [11:0] addr, input logic [63:0] wdata,
                      input logic s, input logic t, input logic e, input logic ack,
                      input logic mr, input logic req, input logic [63:0] cause,
                      input logic [63:0] rdata);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata;
      v.msip = s; v.mtip = t; v.meip = e; v.ack = ack; v.mret = mr;
      v.exp_req = req; v.exp_cause = cause; v.exp_rdata = rdata;
      vq.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      csr_we    = v.we;
      csr_addr  = v.addr;
      csr_wdata = v.wdata;
      msip      = v.msip;
      mtip      = v.mtip;
      meip      = v.meip;
      irq_ack   = v.ack;
      mret      = v.mret;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_req", idx), {63'd0, irq_req}, {63'd0, v.exp_req});
      check($sformatf("v%0d_cause", idx), irq_cause, v.exp_cause);
      check($sformatf("v%0d_rdata", idx), csr_rdata, v.exp_rdata);
   endtask

   initial begin
      //  we addr    wdata    s  t  e  ack mret req cause rdata
      add(1, 12'h300, 64'h0,   0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
      add(0, 12'h304, 64'h0,   0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
      add(0, 12'h344, 64'h0,   0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
      add(1, 12'h304, 64'h80,  0, 0, 0, 0, 0, 0, 64'h0, 64'h80);
      add(1, 12'h300, 64'h8,   0, 0, 0, 0, 0, 0, 64'h0, 64'h8);
      add(0, 12'h344, 64'h0,   0, 1, 0, 0, 0, 1, C7,    64'h80);
      add(0, 12'h300, 64'h0,   0, 1, 0, 1, 0, 0, C7,    64'h80);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 0, 0, C7,    64'h80);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 1, 0, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 0, 1, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 0, 0, 0, 0, 0, C7,    64'h88);
      add(1, 12'h304, ALL,     0, 0, 0, 0, 0, 0, C7,    64'h888);
      add(0, 12'h344, 64'h0,   1, 1, 1, 0, 0, 1, C3,    64'h088);
      add(0, 12'h344, 64'h0,   1, 1, 1, 0, 0, 1, C3,    64'h888);
      add(0, 12'h300, 64'h0,   1, 1, 1, 1, 0, 0, C3,    64'h80);
      add(0, 12'h300, 64'h0,   1, 1, 1, 0, 1, 0, C3,    64'h88);
      add(0, 12'h300, 64'h0,   1, 1, 1, 0, 0, 1, CB,    64'h88);
      add(1, 12'h304, 64'h88,  1, 1, 1, 0, 0, 0, CB,    64'h88);
      add(0, 12'h304, 64'h0,   1, 1, 1, 0, 0, 1, C3,    64'h88);
      add(0, 12'h344, 64'h0,   0, 1, 1, 0, 0, 0, C3,    64'h880);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 0, 1, C7,    64'h88);
      add(1, 12'h300, 64'h0,   0, 1, 0, 0, 0, 0, C7,    64'h0);
      add(0, 12'h300, 64'h0,   0, 1, 0, 1, 0, 0, C7,    64'h0);
      add(1, 12'h300, 64'h88,  0, 1, 0, 0, 0, 0, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 0, 1, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 1, 0, 1, 1, 0, C7,    64'h80);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 1, 0, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 1, 0, 0, 0, 1, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 0, 0, 1, 0, 0, C7,    64'h80);
      add(1, 12'h300, 64'h0,   0, 0, 0, 0, 1, 0, C7,    64'h88);
      add(0, 12'h300, 64'h0,   0, 0, 0, 1, 0, 0, C7,    64'h88);
      add(1, 12'h305, ALL,     0, 0, 0, 0, 0, 0, C7,    64'h0);
      add(0, 12'h304, 64'h0,   0, 0, 0, 0, 0, 0, C7,    64'h88);
      add(1, 12'h344, ALL,     0, 0, 0, 0, 0, 0, C7,    64'h0);
      add(1, 12'h304, 64'h800, 0, 0, 0, 0, 0, 0, C7,    64'h800);
      add(0, 12'h344, 64'h0,   0, 0, 1, 0, 0, 0, C7,    64'h0);
      add(0, 12'h344, 64'h0,   0, 0, 1, 0, 0, 0, C7,    64'h800);
      add(0, 12'h344, 64'h0,   0, 0, 1, 0, 0, 1, CB,    64'h800);

      // Reset state while held in reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", {63'd0, irq_req}, 64'h0);
      check("rst_cause", irq_cause, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

      // Asynchronous reset between clock edges while a request is pending.
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_req", {63'd0, irq_req}, 64'h0);
      check("async_rst_cause", irq_cause, 64'h0);
      csr_we = 1'b0;
      irq_ack = 1'b0;
      mret = 1'b0;
      meip = 1'b0;
      mtip = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      csr_addr = 12'h304;
      #1;
      check("post_rst_mie", csr_rdata, 64'h0);
      csr_addr = 12'h300;
      #1;
      check("post_rst_mstatus", csr_rdata, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_no_req", {63'd0, irq_req}, 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Machine-mode interrupt controller that decides when an interrupt may be taken.
- Owns mstatus.MIE/MPIE and the mie register; synthesises mip from interrupt lines.
- Selects the highest-priority enabled pending interrupt and presents it to the pipeline through a req/ack handshake.
- The pipeline redirects through the CSR unit's trap path with the supplied cause.

Parameters:
Xlen, 64, data/CSR width
SyncStages, 2, synchroniser depth for meip_i (min 2)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
msip_i  input  1  machine software interrupt, synchronous level
mtip_i  input  1  machine timer interrupt, synchronous level
meip_i  input  1  machine external interrupt, asynchronous level
csr_we_i  input  1  CSR write strobe from CSR unit (final value already computed)
csr_addr_i  input  12  CSR address
csr_wdata_i  input  Xlen  CSR write value
csr_rdata_o  output  Xlen  read data for mstatus/mie/mip, combinational from csr_addr_i
irq_req_o  output  1  interrupt request to pipeline
irq_cause_o  output  Xlen  mcause value for the request
irq_ack_i  input  1  pipeline takes interrupt this cycle (asserted only at an instruction boundary)
mret_i  input  1  mret retiring this cycle

Behaviour:
- Reset (async, rst_i=1):
  - All state is 0: mie, MIE, MPIE, FSM=IDLE, synchroniser flops.
  - irq_req_o=0, irq_cause_o=0.
- meip_i path: SyncStages-flop synchroniser gives meip_s. msip_i/mtip_i are used directly.
- mip: bit3=msip_i, bit7=mtip_i, bit11=meip_s, other bits 0. Writes to mip are ignored.
- mie: only bits 3/7/11 are writable; other bits read 0.
- mstatus: only bit3 (MIE) and bit7 (MPIE) are implemented; all other bits read 0.
- CSR addresses: 0x300 mstatus, 0x304 mie, 0x344 mip. Any other address reads 0 and writes are ignored.
- Pending vector: pend = mip & mie.
- Priority: bit11 > bit3 > bit7.
- Cause encoding: bit Xlen-1 set, low bits = 11/3/7.
  - Example: MEI gives 0x8000_0000_0000_000B.
- Eligibility: elig = MIE & |pend.
- FSM is registered, with states IDLE and REQ:
  - IDLE: if elig, go to REQ next cycle and latch irq_cause_o from the highest-priority pend bit.
  - REQ:
    - irq_req_o=1; irq_cause_o is held stable.
    - On irq_ack_i: go to IDLE, MPIE<=MIE, MIE<=0.
    - Else, if the latched source is no longer in pend or MIE=0: withdraw to IDLE with irq_req_o=0 next cycle.
    - A higher-priority source arriving while in REQ does not change the cause. It is considered after returning to IDLE.
  - irq_req_o = (state==REQ).
  - Latency: pend rising to irq_req_o is 1 cycle; for meip_i it is SyncStages+1 cycles.
- mret_i: MIE<=MPIE, MPIE<=1.
- Precedence for MIE/MPIE updates in the same cycle: irq_ack_i > mret_i > CSR write.
- Same-cycle irq_ack_i and a withdraw condition: the ack wins and the interrupt is taken.
- irq_ack_i while in IDLE is ignored. No state change occurs.
- CSR write clearing MIE while in REQ with no ack: withdraw. irq_req_o falls on the following cycle.
- A reset asserted while in REQ forces IDLE immediately (async), and irq_req_o drops without waiting for a clock.

Test Plan:
- Reset, then write mie=0x80 and mstatus=0x8, raise mtip_i → irq_req_o=1 one cycle later with cause 0x8000_0000_0000_0007. Then ack → irq_req_o=0 next cycle and mstatus reads 0x80.
- In the taken state, pulse mret_i → mstatus reads 0x88. Since mtip_i is still high, irq_req_o re-asserts the next cycle.
- Enable all three sources, assert msip_i, mtip_i and meip_i together → first request has cause 3 (meip is still in the synchroniser). After ack and mret, the next request has cause 11.
- In REQ, drop msip_i with no ack → irq_req_o=0 next cycle and state is IDLE. Repeat, but write mstatus=0 in REQ → same withdraw.
- Same cycle irq_ack_i and mret_i in REQ → MIE=0 and MPIE=previous MIE (ack wins).
- Assert rst_i mid-REQ between clock edges → irq_req_o falls immediately. mie/mstatus read 0 after release.
